// File: rtl/vector_alu_sequencer_pkg.sv
// vector_alu_sequencer_pkg: shared ALU opcodes, state encoding and default widths
package vector_alu_sequencer_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int OP_W = 5;
    localparam logic [OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB = 5'd1;
    localparam logic [OP_W-1:0] OP_AND = 5'd2;
    localparam logic [OP_W-1:0] OP_OR = 5'd3;
    localparam logic [OP_W-1:0] OP_XOR = 5'd4;
    localparam logic [OP_W-1:0] OP_EQ = 5'd5;
    localparam logic [OP_W-1:0] OP_LT = 5'd6;
    localparam logic [OP_W-1:0] OP_SELA = 5'd7;
    localparam logic [OP_W-1:0] OP_SELB = 5'd8;
    localparam logic [OP_W-1:0] MAX_OP = OP_SELB;
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WR, FIN} state_t;
endpackage

// File: rtl/vector_alu_sequencer_if.sv
// vector_alu_sequencer_if: command, status, memory and ALU signals of the sequencer
interface vector_alu_sequencer_if #(
    parameter int DATA_W = vector_alu_sequencer_pkg::DATA_W,
    parameter int ADDR_W = vector_alu_sequencer_pkg::ADDR_W,
    parameter int OP_W = vector_alu_sequencer_pkg::OP_W
);
    logic start;
    logic [OP_W-1:0] op;
    logic scalar_b;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] base_dst;
    logic [ADDR_W-1:0] length;
    logic busy;
    logic done;
    logic err;
    logic [ADDR_W-1:0] mem_addr;
    logic mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0] alu_op;
    logic [DATA_W-1:0] alu_out;
    modport master (
        output start, op, scalar_b, base_a, base_b, base_dst, length, mem_rdata, alu_out,
        input busy, done, err, mem_addr, mem_we, mem_wdata, alu_a, alu_b, alu_op
    );
    modport slave (
        input start, op, scalar_b, base_a, base_b, base_dst, length, mem_rdata, alu_out,
        output busy, done, err, mem_addr, mem_we, mem_wdata, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/vseq_addr_gen.sv
// vseq_addr_gen: element index counter, base+idx address adders and last-element flag
module vseq_addr_gen #(
    parameter int ADDR_W = vector_alu_sequencer_pkg::ADDR_W
) (
    input logic CLK,
    input logic Reset,
    input logic clr,
    input logic inc,
    input logic [ADDR_W-1:0] base_a,
    input logic [ADDR_W-1:0] base_b,
    input logic [ADDR_W-1:0] base_dst,
    input logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [ADDR_W-1:0] addr_dst,
    output logic last
);
    logic [ADDR_W-1:0] idx;
    // index restarts in IDLE and advances after each element write
    always_ff @(posedge CLK) begin
        if (Reset || clr) idx <= '0;
        else if (inc) idx <= idx + 1'b1;
    end
    assign addr_a = base_a + idx;
    assign addr_b = base_b + idx;
    assign addr_dst = base_dst + idx;
    assign last = idx == length - 1'b1;
endmodule

// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer: streams vector operands from memory through the ALU and writes results back
module vector_alu_sequencer #(
    parameter int DATA_W = vector_alu_sequencer_pkg::DATA_W,
    parameter int ADDR_W = vector_alu_sequencer_pkg::ADDR_W,
    parameter int OP_W = vector_alu_sequencer_pkg::OP_W,
    parameter logic [OP_W-1:0] MAX_OP = vector_alu_sequencer_pkg::MAX_OP
) (
    input logic CLK,
    input logic Reset,
    vector_alu_sequencer_if.slave bus
);
    import vector_alu_sequencer_pkg::*;
    state_t state, state_nx;
    logic scalar_q;
    logic [ADDR_W-1:0] base_a_q, base_b_q, base_dst_q, len_q;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_dst;
    logic last;
    logic accept;
    assign accept = state == IDLE && bus.start && bus.op <= MAX_OP;
    vseq_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
        .CLK(CLK),
        .Reset(Reset),
        .clr(state == IDLE),
        .inc(state == WR && !last),
        .base_a(base_a_q),
        .base_b(base_b_q),
        .base_dst(base_dst_q),
        .length(len_q),
        .addr_a(addr_a),
        .addr_b(addr_b),
        .addr_dst(addr_dst),
        .last(last)
    );
    // state register
    always_ff @(posedge CLK) state <= Reset ? IDLE : state_nx;
    // command latch on accepted start; err pulse on rejected opcode
    always_ff @(posedge CLK) begin
        if (Reset) begin
            scalar_q <= 1'b0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_dst_q <= '0;
            len_q <= '0;
            bus.alu_op <= '0;
            bus.err <= 1'b0;
        end else begin
            bus.err <= state == IDLE && bus.start && bus.op > MAX_OP;
            if (accept) begin
                scalar_q <= bus.scalar_b;
                base_a_q <= bus.base_a;
                base_b_q <= bus.base_b;
                base_dst_q <= bus.base_dst;
                len_q <= bus.length;
                bus.alu_op <= bus.op;
            end
        end
    end
    // operand capture: read data lands one cycle after its address phase
    always_ff @(posedge CLK) begin
        if (Reset) begin
            bus.alu_a <= '0;
            bus.alu_b <= '0;
        end else begin
            if (state == RD_B || (state == EXEC && scalar_q)) bus.alu_a <= bus.mem_rdata;
            if (state == EXEC) bus.alu_b <= scalar_q ? DATA_W'(base_b_q) : bus.mem_rdata;
        end
    end
    // next state and memory/status outputs
    always_comb begin
        state_nx = state;
        bus.mem_addr = '0;
        bus.mem_we = 1'b0;
        bus.mem_wdata = {DATA_W{1'b0}};
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            IDLE: if (accept) state_nx = bus.length == '0 ? FIN : RD_A;
            RD_A: begin
                bus.busy = 1'b1;
                bus.mem_addr = addr_a;
                state_nx = scalar_q ? EXEC : RD_B;
            end
            RD_B: begin
                bus.busy = 1'b1;
                bus.mem_addr = addr_b;
                state_nx = EXEC;
            end
            EXEC: begin
                bus.busy = 1'b1;
                state_nx = WR;
            end
            WR: begin
                bus.busy = 1'b1;
                bus.mem_addr = addr_dst;
                bus.mem_we = 1'b1;
                bus.mem_wdata = bus.alu_out;
                state_nx = last ? FIN : RD_A;
            end
            FIN: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
